// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: ALU codes, operand selects,
// default widths and the output-register state type.
package alu_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

   localparam logic [1:0] A_SEL_RS1  = 2'b00;
   localparam logic [1:0] A_SEL_PC   = 2'b01;
   localparam logic [1:0] A_SEL_ZERO = 2'b10;

   localparam logic [1:0] B_SEL_RS2  = 2'b00;
   localparam logic [1:0] B_SEL_IMM  = 2'b01;
   localparam logic [1:0] B_SEL_FOUR = 2'b10;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, bypass and execute-side signals of the ALU operand stage.
// master = surrounding pipeline, slave = the operand stage.
interface alu_operand_stage_if
   import alu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
);
   logic              valid_w_i_h;
   logic              ready_w_o_h;
   logic [XLEN-1:0]   rs1_data_w_i;
   logic [XLEN-1:0]   rs2_data_w_i;
   logic [REG_AW-1:0] rs1_addr_w_i;
   logic [REG_AW-1:0] rs2_addr_w_i;
   logic [REG_AW-1:0] rd_addr_w_i;
   logic [XLEN-1:0]   imm_w_i;
   logic [XLEN-1:0]   pc_w_i;
   logic [1:0]        a_sel_w_i;
   logic [1:0]        b_sel_w_i;
   logic [3:0]        alu_control_w_i;
   logic              flush_w_i_h;
   logic              fwd_mem_en_w_i_h;
   logic              fwd_mem_load_w_i_h;
   logic [REG_AW-1:0] fwd_mem_rd_w_i;
   logic [XLEN-1:0]   fwd_mem_data_w_i;
   logic              fwd_wb_en_w_i_h;
   logic [REG_AW-1:0] fwd_wb_rd_w_i;
   logic [XLEN-1:0]   fwd_wb_data_w_i;
   logic              valid_w_o_h;
   logic              ready_w_i_h;
   logic [XLEN-1:0]   a_data_w_o;
   logic [XLEN-1:0]   b_data_w_o;
   logic [3:0]        alu_control_w_o;
   logic [XLEN-1:0]   store_data_w_o;
   logic [REG_AW-1:0] rd_addr_w_o;

   modport master (
      output valid_w_i_h, rs1_data_w_i, rs2_data_w_i, rs1_addr_w_i, rs2_addr_w_i,
             rd_addr_w_i, imm_w_i, pc_w_i, a_sel_w_i, b_sel_w_i, alu_control_w_i,
             flush_w_i_h, fwd_mem_en_w_i_h, fwd_mem_load_w_i_h, fwd_mem_rd_w_i,
             fwd_mem_data_w_i, fwd_wb_en_w_i_h, fwd_wb_rd_w_i, fwd_wb_data_w_i,
             ready_w_i_h,
      input  ready_w_o_h, valid_w_o_h, a_data_w_o, b_data_w_o, alu_control_w_o,
             store_data_w_o, rd_addr_w_o
   );

   modport slave (
      input  valid_w_i_h, rs1_data_w_i, rs2_data_w_i, rs1_addr_w_i, rs2_addr_w_i,
             rd_addr_w_i, imm_w_i, pc_w_i, a_sel_w_i, b_sel_w_i, alu_control_w_i,
             flush_w_i_h, fwd_mem_en_w_i_h, fwd_mem_load_w_i_h, fwd_mem_rd_w_i,
             fwd_mem_data_w_i, fwd_wb_en_w_i_h, fwd_wb_rd_w_i, fwd_wb_data_w_i,
             ready_w_i_h,
      output ready_w_o_h, valid_w_o_h, a_data_w_o, b_data_w_o, alu_control_w_o,
             store_data_w_o, rd_addr_w_o
   );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-source bypass select: EX/MEM result beats WB result beats register file.
// x0 and in-flight loads are never bypassed.
module operand_fwd_mux
   import alu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [XLEN-1:0]   rf_data,
   input  logic              mem_en,
   input  logic              mem_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   fwd_data
);

   logic src_nonzero;
   logic mem_hit;
   logic wb_hit;

   assign src_nonzero = (addr != '0);
   assign mem_hit     = mem_en && !mem_load && (mem_rd == addr) && src_nonzero;
   assign wb_hit      = wb_en && (wb_rd == addr) && src_nonzero;

   always_comb begin
      fwd_data = rf_data;
      if (mem_hit) begin
         fwd_data = mem_data;
      end else if (wb_hit) begin
         fwd_data = wb_data;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/execute register in front of the ALU: bypassed operand select,
// load-use stall and a one-entry valid/ready output register.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic                clk_w_i,
   input  logic                rst_w_i_l,
   alu_operand_stage_if.slave  bus
);

   logic [XLEN-1:0]   rs1_fwd;
   logic [XLEN-1:0]   rs2_fwd;
   logic [XLEN-1:0]   a_mux;
   logic [XLEN-1:0]   b_mux;
   logic              hazard;
   logic              ready;
   logic              accept;
   logic              vld_p0;
   stage_state_e      state_q;
   stage_state_e      state_d;
   logic [XLEN-1:0]   a_data_p0;
   logic [XLEN-1:0]   b_data_p0;
   logic [XLEN-1:0]   store_data_p0;
   logic [3:0]        alu_control_p0;
   logic [REG_AW-1:0] rd_addr_p0;

   operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .addr     (bus.rs1_addr_w_i),
      .rf_data  (bus.rs1_data_w_i),
      .mem_en   (bus.fwd_mem_en_w_i_h),
      .mem_load (bus.fwd_mem_load_w_i_h),
      .mem_rd   (bus.fwd_mem_rd_w_i),
      .mem_data (bus.fwd_mem_data_w_i),
      .wb_en    (bus.fwd_wb_en_w_i_h),
      .wb_rd    (bus.fwd_wb_rd_w_i),
      .wb_data  (bus.fwd_wb_data_w_i),
      .fwd_data (rs1_fwd)
   );

   operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .addr     (bus.rs2_addr_w_i),
      .rf_data  (bus.rs2_data_w_i),
      .mem_en   (bus.fwd_mem_en_w_i_h),
      .mem_load (bus.fwd_mem_load_w_i_h),
      .mem_rd   (bus.fwd_mem_rd_w_i),
      .mem_data (bus.fwd_mem_data_w_i),
      .wb_en    (bus.fwd_wb_en_w_i_h),
      .wb_rd    (bus.fwd_wb_rd_w_i),
      .wb_data  (bus.fwd_wb_data_w_i),
      .fwd_data (rs2_fwd)
   );

   always_comb begin
      case (bus.a_sel_w_i)
         A_SEL_PC:   a_mux = bus.pc_w_i;
         A_SEL_ZERO: a_mux = '0;
         default:    a_mux = rs1_fwd;
      endcase
   end

   always_comb begin
      case (bus.b_sel_w_i)
         B_SEL_IMM:  b_mux = bus.imm_w_i;
         B_SEL_FOUR: b_mux = XLEN'(4);
         default:    b_mux = rs2_fwd;
      endcase
   end

   // Both sources are checked whatever the selects say, so the stall is conservative.
   assign hazard = bus.valid_w_i_h && bus.fwd_mem_en_w_i_h && bus.fwd_mem_load_w_i_h &&
                   (bus.fwd_mem_rd_w_i != '0) &&
                   ((bus.fwd_mem_rd_w_i == bus.rs1_addr_w_i) ||
                    (bus.fwd_mem_rd_w_i == bus.rs2_addr_w_i));

   assign vld_p0 = (state_q == ST_FULL);
   assign ready  = (!vld_p0 || bus.ready_w_i_h) && !hazard;
   assign accept = bus.valid_w_i_h && ready && !bus.flush_w_i_h;

   always_ff @(posedge clk_w_i) begin
      if (!rst_w_i_l) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush_w_i_h) begin
         state_d = ST_EMPTY;
      end else if (accept) begin
         state_d = ST_FULL;
      end else if (vld_p0 && bus.ready_w_i_h) begin
         state_d = ST_EMPTY;
      end
   end

   // Stage p0: operands registered for the ALU, held bit-exact while not accepting.
   always_ff @(posedge clk_w_i) begin
      if (!rst_w_i_l) begin
         a_data_p0      <= '0;
         b_data_p0      <= '0;
         store_data_p0  <= '0;
         alu_control_p0 <= 4'(ALU_ADD);
         rd_addr_p0     <= '0;
      end else if (accept) begin
         a_data_p0      <= a_mux;
         b_data_p0      <= b_mux;
         store_data_p0  <= rs2_fwd;
         alu_control_p0 <= bus.alu_control_w_i;
         rd_addr_p0     <= bus.rd_addr_w_i;
      end
   end

   assign bus.ready_w_o_h     = ready;
   assign bus.valid_w_o_h     = vld_p0;
   assign bus.a_data_w_o      = a_data_p0;
   assign bus.b_data_w_o      = b_data_p0;
   assign bus.store_data_w_o  = store_data_p0;
   assign bus.alu_control_w_o = alu_control_p0;
   assign bus.rd_addr_w_o     = rd_addr_p0;

endmodule
